// File: rtl/frame_buffer_pkg.sv
// Shared types and default sizing for the frame buffer sequencer.
package frame_buffer_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOF = 2'd1,
      CAPTURE  = 2'd2,
      READOUT  = 2'd3
   } fb_state_e;

   localparam int DEF_DATA_W       = 15;
   localparam int DEF_ADDR_W       = 17;
   localparam int DEF_FRAME_PIXELS = 76800;
   localparam int LAST_ADDR        = DEF_FRAME_PIXELS - 1;

endpackage

// File: rtl/fb_skid_buffer.sv
// Two-entry valid/ready buffer behind the 1-cycle-latency memory read port.
// Tracks the read in flight itself so the credit it reports covers both
// stored entries and data still coming back from the memory.
module fb_skid_buffer #(
   parameter int DATA_W = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue,
   input  logic              issue_last,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              credit
);

   logic [1:0]        count_q, count_d;
   logic              pend_q, pend_d;
   logic              pend_last_q, pend_last_d;
   logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
   logic              last0_q, last0_d, last1_q, last1_d;
   logic              pop;
   logic [2:0]        occ;

   assign out_valid = (count_q != 2'd0);
   assign out_data  = data0_q;
   assign out_last  = out_valid & last0_q;
   assign pop       = out_valid & out_ready;

   // occupancy once this cycle's pop is taken, so a full-rate stream needs no bubble
   assign occ    = {1'b0, count_q} + {2'b00, pend_q} - {2'b00, pop};
   assign credit = (occ < 3'd2);

   // pop shifts the head, then returning read data lands in the first free slot
   always_comb begin
      count_d     = count_q;
      data0_d     = data0_q;
      data1_d     = data1_q;
      last0_d     = last0_q;
      last1_d     = last1_q;
      pend_d      = issue;
      pend_last_d = issue & issue_last;
      if (pop) begin
         data0_d = data1_q;
         last0_d = last1_q;
         count_d = count_q - 2'd1;
      end
      if (pend_q) begin
         if (count_d == 2'd0) begin
            data0_d = rd_data;
            last0_d = pend_last_q;
         end else begin
            data1_d = rd_data;
            last1_d = pend_last_q;
         end
         count_d = count_d + 2'd1;
      end
   end

   // buffer registers
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q     <= 2'd0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         data0_q     <= '0;
         data1_q     <= '0;
         last0_q     <= 1'b0;
         last1_q     <= 1'b0;
      end else begin
         count_q     <= count_d;
         pend_q      <= pend_d;
         pend_last_q <= pend_last_d;
         data0_q     <= data0_d;
         data1_q     <= data1_d;
         last0_q     <= last0_d;
         last1_q     <= last1_d;
      end
   end

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Frame capture / readout sequencer for the dual-port frame memory.
// Build option: FRAME_BUFFER_CTRL_CONTINUOUS_EN -- after frame_done go
// straight back to WAIT_SOF and capture frames back-to-back.
//
// state    | meaning
// IDLE     | waiting for start
// WAIT_SOF | discarding pixels until a start-of-frame pixel
// CAPTURE  | writing pixels at wr_ptr until the last address is written
// READOUT  | reading the frame out through the skid buffer
module frame_buffer_ctrl
   import frame_buffer_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int FRAME_PIXELS = DEF_FRAME_PIXELS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              frame_done,
   output logic              overrun_err,
   input  logic              in_valid,
   input  logic              in_sof,
   input  logic [DATA_W-1:0] in_data,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_PIXELS - 1);

   fb_state_e         state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              rd_done_q, rd_done_d;
   logic              overrun_q, overrun_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              credit;

   assign busy        = (state_q != IDLE);
   assign overrun_err = overrun_q;
   assign mem_wr_en   = wr_en_q;
   assign mem_wr_addr = wr_addr_q;
   assign mem_wr_data = wr_data_q;
   assign mem_rd_addr = rd_addr_q;

   fb_skid_buffer #(.DATA_W(DATA_W)) u_skid (
      .clk        (clk),
      .reset      (reset),
      .issue      (mem_rd_en),
      .issue_last (rd_addr_q == LAST),
      .rd_data    (mem_rd_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .credit     (credit)
   );

   // next-state, write-port and read-issue logic
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_addr_d  = rd_addr_q;
      rd_done_d  = rd_done_q;
      overrun_d  = overrun_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      mem_rd_en  = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = WAIT_SOF;
               overrun_d = 1'b0;
            end
         end
         WAIT_SOF: begin
            if (in_valid && in_sof) begin
               wr_en_d   = 1'b1;
               wr_addr_d = '0;
               wr_data_d = in_data;
               wr_ptr_d  = ADDR_W'(1);
               state_d   = CAPTURE;
            end
         end
         CAPTURE: begin
            // readout starts only once the last write has been presented
            if (wr_en_q && (wr_addr_q == LAST)) begin
               state_d = READOUT;
            end else if (in_valid) begin
               wr_en_d   = 1'b1;
               wr_data_d = in_data;
               if (in_sof) begin
                  overrun_d = 1'b1;
                  wr_addr_d = '0;
                  wr_ptr_d  = ADDR_W'(1);
               end else begin
                  wr_addr_d = wr_ptr_q;
                  if (wr_ptr_q != LAST) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
               end
            end
         end
         READOUT: begin
            mem_rd_en = credit & ~rd_done_q;
            if (mem_rd_en) begin
               if (rd_addr_q == LAST) rd_done_d = 1'b1;
               else                   rd_addr_d = rd_addr_q + ADDR_W'(1);
            end
            if (out_valid && out_ready && out_last) begin
               frame_done = 1'b1;
               wr_ptr_d   = '0;
               rd_addr_d  = '0;
               rd_done_d  = 1'b0;
`ifdef FRAME_BUFFER_CTRL_CONTINUOUS_EN
               state_d    = WAIT_SOF;
`else
               state_d    = IDLE;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state, counters and registered write port
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_addr_q <= '0;
         rd_done_q <= 1'b0;
         overrun_q <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_addr_q <= rd_addr_d;
         rd_done_q <= rd_done_d;
         overrun_q <= overrun_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Scoreboard bench for frame_buffer_ctrl with a 16-pixel frame and a
// 1-cycle-latency behavioural memory.
module tb_frame_buffer_ctrl;

   localparam int DW = 15;
   localparam int AW = 17;
   localparam int FP = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1, start = 1'b0;
   logic          in_valid = 1'b0, in_sof = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          busy, frame_done, overrun_err;
   logic          mem_wr_en, mem_rd_en, out_valid, out_last, out_ready;
   logic [AW-1:0] mem_wr_addr, mem_rd_addr;
   logic [DW-1:0] mem_wr_data, mem_rd_data, out_data;
   logic          rnd_rdy = 1'b0, rand_rdy = 1'b0, rdy_fixed = 1'b1;

   always #5 clk = ~clk;

   frame_buffer_ctrl #(.DATA_W(DW), .ADDR_W(AW), .FRAME_PIXELS(FP)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy),
      .frame_done(frame_done), .overrun_err(overrun_err),
      .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last)
   );

   logic [DW-1:0] mem [0:255];
   always @(posedge clk) begin
      if (mem_wr_en) mem[mem_wr_addr[7:0]] <= mem_wr_data;
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr[7:0]];
   end

   always @(posedge clk) begin
      #1;
      rnd_rdy = 1'($urandom_range(0, 1));
   end
   assign out_ready = rand_rdy ? rnd_rdy : rdy_fixed;

   logic [AW+DW-1:0] exp_wr_q [$];
   logic [DW:0]      exp_out_q [$];
   int errors = 0, checks = 0;
   int cyc = 0, issued = 0, accepted = 0, max_out = 0;
   int done_cnt = 0, first_acc = -1, last_done = -1;
   logic          stall_q = 1'b0;
   logic [DW:0]   stall_val = '0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: pops expected writes/beats whenever the DUT presents them
   always @(negedge clk) begin
      cyc++;
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (mem_wr_en) begin
         if (exp_wr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: got addr %0d data %0d expected no write", mem_wr_addr, mem_wr_data);
         end else check("write", {mem_wr_addr, mem_wr_data}, exp_wr_q.pop_front());
      end
      if (stall_q) check("stall_hold", {out_valid, out_last, out_data}, {1'b1, stall_val});
      if (out_valid && out_ready) begin
         accepted++;
         if (first_acc < 0) first_acc = cyc;
         if (exp_out_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got data %0d last %0b expected no beat", out_data, out_last);
         end else check("out_beat", {out_last, out_data}, exp_out_q.pop_front());
      end
      if (frame_done) begin
         done_cnt++;
         last_done = cyc;
      end
      if (mem_rd_en) issued++;
      stall_q   = out_valid && !out_ready;
      stall_val = {out_last, out_data};
      if (reset) begin
         issued = 0; accepted = 0; stall_q = 1'b0;
      end
   end

   task automatic pix(input logic sof, input logic [DW-1:0] d);
      @(posedge clk); #1;
      in_valid = 1'b1; in_sof = sof; in_data = d;
   endtask

   task automatic idle_in();
      @(posedge clk); #1;
      in_valid = 1'b0; in_sof = 1'b0;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   // a full sof-led frame: expects writes at 0..FP-1 and the same pixels out
   task automatic frame(input logic [DW-1:0] base);
      first_acc = -1;
      done_cnt  = 0;
      for (int i = 0; i < FP; i++) begin
         exp_wr_q.push_back({AW'(i), base + DW'(i)});
         exp_out_q.push_back({(i == FP - 1), base + DW'(i)});
      end
      for (int i = 0; i < FP; i++) pix(i == 0, base + DW'(i));
      idle_in();
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (done_cnt == 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      check(name, done_cnt, 1);
      @(negedge clk);
      check({name, "_pulse_len"}, frame_done, 0);
`ifdef FRAME_BUFFER_CTRL_CONTINUOUS_EN
      check({name, "_busy_after"}, busy, 1);
`else
      check({name, "_busy_after"}, busy, 0);
`endif
   endtask

   task automatic do_reset(input string name);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check(name, {busy, frame_done, overrun_err, mem_wr_en, mem_wr_addr, mem_wr_data,
                   mem_rd_en, mem_rd_addr, out_valid, out_data, out_last}, '0);
      exp_out_q.delete();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      do_reset("reset_outputs");

      // 1: basic frame at full rate
      pulse_start();
      frame(15'd1);
      wait_done("t1_done");
      check("t1_no_bubbles", last_done - first_acc, FP - 1);

      // 2: pixels before sof are dropped
      pulse_start();
      for (int i = 0; i < 5; i++) pix(1'b0, 15'd100 + DW'(i));
      frame(15'd200);
      wait_done("t2_done");
      check("t2_overrun_clear", overrun_err, 0);

      // 3: second sof at pixel 7 restarts the frame
      pulse_start();
      for (int i = 0; i < 6; i++) begin
         exp_wr_q.push_back({AW'(i), 15'd300 + DW'(i)});
         pix(i == 0, 15'd300 + DW'(i));
      end
      frame(15'd400);
      wait_done("t3_done");
      check("t3_overrun", overrun_err, 1);

      // 4: random backpressure
      pulse_start();
      @(negedge clk);
`ifdef FRAME_BUFFER_CTRL_CONTINUOUS_EN
      check("t4_overrun_start", overrun_err, 1);
`else
      check("t4_overrun_cleared", overrun_err, 0);
`endif
      rand_rdy = 1'b1;
      frame(15'd500);
      wait_done("t4_done");
      rand_rdy = 1'b0;
      check("t4_max_outstanding", (max_out <= 2), 1);

      // 5: reset mid-capture, reset mid-readout, then a clean frame
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         exp_wr_q.push_back({AW'(i), 15'd600 + DW'(i)});
         pix(i == 0, 15'd600 + DW'(i));
      end
      idle_in();
      do_reset("t5_reset_capture");
      check("t5_writes_drained", exp_wr_q.size(), 0);
      rdy_fixed = 1'b0;
      pulse_start();
      frame(15'd700);
      begin
         int n = 0;
         while (!out_valid && n < 100) begin
            @(posedge clk); #2;
            n++;
         end
      end
      check("t5_readout_reached", out_valid, 1);
      repeat (3) @(posedge clk);
      do_reset("t5_reset_readout");
      rdy_fixed = 1'b1;
      pulse_start();
      frame(15'd800);
      wait_done("t5_done");
      check("t5_no_bubbles", last_done - first_acc, FP - 1);

      check("wr_queue_empty", exp_wr_q.size(), 0);
      check("out_queue_empty", exp_out_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
